dual_port_ram: RTL and testbench

Parametrised dual-port, word-addressed synchronous RAM that succeeds the unified single-port memory with a Harvard-style split. Port A is a read-only instruction fetch port. Port B is a read/write data port with byte enables, defined simultaneous-access behaviour and out-of-range error reporting. It sits between the fetch stage (port A) and the load/store unit (port B) and shares one storage array, so self-modifying code stays coherent.

---
 rtl/dual_port_ram.sv | 124 ++++++++++++
 tb/tb_dual_port_ram.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram.sv
// dual_port_ram: shared word-addressed storage with a read-only fetch port (A)
// and a byte-enabled read/write data port (B). Out-of-range requests report
// an error pulse and set a sticky flag instead of touching the array.
module dual_port_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_rd_en,
  input  logic [ADDR_W-1:0]     a_addr,
  output logic [DATA_W-1:0]     a_dout,
  output logic                  a_valid,
  output logic                  a_err,
  input  logic                  b_rd_en,
  input  logic                  b_wr_en,
  input  logic [DATA_W/8-1:0]   b_be,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_din,
  output logic [DATA_W-1:0]     b_dout,
  output logic                  b_valid,
  output logic                  b_err,
  output logic                  err_sticky,
  input  logic                  err_clr
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  // Storage is never reset; contents are undefined until written.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              a_in_range;
  logic              b_in_range;
  logic [IDX_W-1:0]  a_idx;
  logic [IDX_W-1:0]  b_idx;
  logic              b_req;
  logic              b_wr_fire;
  logic [DATA_W-1:0] b_old;
  logic [DATA_W-1:0] b_merged;

  logic [DATA_W-1:0] a_dout_reg, a_dout_next;
  logic              a_valid_reg, a_valid_next;
  logic              a_err_reg, a_err_next;
  logic [DATA_W-1:0] b_dout_reg, b_dout_next;
  logic              b_valid_reg, b_valid_next;
  logic              b_err_reg, b_err_next;
  logic              err_sticky_reg, err_sticky_next;

  assign a_in_range = ({1'b0, a_addr} < DEPTH_LIM);
  assign b_in_range = ({1'b0, b_addr} < DEPTH_LIM);
  assign a_idx      = a_addr[IDX_W-1:0];
  assign b_idx      = b_addr[IDX_W-1:0];
  assign b_req      = b_rd_en | b_wr_en;
  assign b_wr_fire  = b_wr_en & b_in_range & ~rst;
  assign b_old      = mem[b_idx];

  // Post-write view of the port B word, so a combined read+write returns
  // the merged data (write-first on port B).
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_merge
      assign b_merged[8*gi +: 8] = (b_wr_en && b_be[gi]) ? b_din[8*gi +: 8]
                                                         : b_old[8*gi +: 8];
    end
  endgenerate

  // Byte-lane writes from port B; dropped while in reset or out of range.
  always_ff @(posedge clk) begin
    if (b_wr_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (b_be[i]) mem[b_idx][8*i +: 8] <= b_din[8*i +: 8];
      end
    end
  end

  // Next-state for read data, handshake pulses and the sticky error flag.
  // Port A samples the array before this edge's write lands (read-first).
  always_comb begin
    a_dout_next     = a_dout_reg;
    a_valid_next    = a_rd_en;
    a_err_next      = a_rd_en & ~a_in_range;
    b_dout_next     = b_dout_reg;
    b_valid_next    = b_req;
    b_err_next      = b_req & ~b_in_range;
    err_sticky_next = err_sticky_reg;
    if (a_rd_en) a_dout_next = a_in_range ? mem[a_idx] : '0;
    if (b_rd_en) b_dout_next = b_in_range ? b_merged : '0;
    if (a_err_next || b_err_next) err_sticky_next = 1'b1;
    else if (err_clr)             err_sticky_next = 1'b0;
  end

  // Output registers; requests seen during reset are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_dout_reg     <= '0;
      a_valid_reg    <= 1'b0;
      a_err_reg      <= 1'b0;
      b_dout_reg     <= '0;
      b_valid_reg    <= 1'b0;
      b_err_reg      <= 1'b0;
      err_sticky_reg <= 1'b0;
    end else begin
      a_dout_reg     <= a_dout_next;
      a_valid_reg    <= a_valid_next;
      a_err_reg      <= a_err_next;
      b_dout_reg     <= b_dout_next;
      b_valid_reg    <= b_valid_next;
      b_err_reg      <= b_err_next;
      err_sticky_reg <= err_sticky_next;
    end
  end

  assign a_dout     = a_dout_reg;
  assign a_valid    = a_valid_reg;
  assign a_err      = a_err_reg;
  assign b_dout     = b_dout_reg;
  assign b_valid    = b_valid_reg;
  assign b_err      = b_err_reg;
  assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: directed test-plan scenarios followed by random traffic,
// checked by a negedge monitor against queues filled by a word-array model.
module tb_dual_port_ram;

  localparam int DW    = 32;
  localparam int DEPTH = 512;
  localparam int AW    = 16;
  localparam int NB    = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_rd_en;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_dout;
  logic          a_valid;
  logic          a_err;
  logic          b_rd_en;
  logic          b_wr_en;
  logic [NB-1:0] b_be;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_din;
  logic [DW-1:0] b_dout;
  logic          b_valid;
  logic          b_err;
  logic          err_sticky;
  logic          err_clr;

  always #5 clk = ~clk;

  dual_port_ram #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .a_rd_en(a_rd_en), .a_addr(a_addr), .a_dout(a_dout),
    .a_valid(a_valid), .a_err(a_err),
    .b_rd_en(b_rd_en), .b_wr_en(b_wr_en), .b_be(b_be), .b_addr(b_addr),
    .b_din(b_din), .b_dout(b_dout), .b_valid(b_valid), .b_err(b_err),
    .err_sticky(err_sticky), .err_clr(err_clr)
  );

  typedef struct {
    int unsigned cyc;
    logic [DW-1:0] dout;
    logic err;
  } txn_t;

  typedef struct {
    logic sticky;
    logic [DW-1:0] a_hold;
    logic [DW-1:0] b_hold;
  } cyc_t;

  txn_t a_q[$];
  txn_t b_q[$];
  cyc_t c_q[$];

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;
  logic          sticky_m = 1'b0;

  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Issue one cycle of stimulus and record what the memory should answer.
  task automatic step(input logic r, input logic ar, input logic [AW-1:0] aa,
                      input logic br, input logic bw, input logic [NB-1:0] be,
                      input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic clr);
    logic in_a, in_b, errs;
    logic [DW-1:0] d;
    rst = r; a_rd_en = ar; a_addr = aa; b_rd_en = br; b_wr_en = bw;
    b_be = be; b_addr = ba; b_din = bd; err_clr = clr;
    if (r) begin
      last_a = '0; last_b = '0; sticky_m = 1'b0;
    end else begin
      errs = 1'b0;
      in_a = (int'(aa) < DEPTH);
      in_b = (int'(ba) < DEPTH);
      if (ar) begin
        d = in_a ? model[aa[8:0]] : '0;
        a_q.push_back('{cyc, d, !in_a});
        last_a = d;
        errs = errs | !in_a;
      end
      if (br || bw) begin
        if (bw && in_b) begin
          for (int j = 0; j < NB; j++)
            if (be[j]) model[ba[8:0]][8*j +: 8] = bd[8*j +: 8];
        end
        d = br ? (in_b ? model[ba[8:0]] : '0) : last_b;
        b_q.push_back('{cyc, d, !in_b});
        last_b = d;
        errs = errs | !in_b;
      end
      if (errs)     sticky_m = 1'b1;
      else if (clr) sticky_m = 1'b0;
    end
    c_q.push_back('{sticky_m, last_a, last_b});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [AW-1:0] ad, input logic [DW-1:0] dt, input logic [NB-1:0] be);
    step(0, 0, 0, 0, 1, be, ad, dt, 0);
  endtask

  // Monitor: a transaction is due exactly one cycle after issue.
  always @(negedge clk) begin : mon
    cyc_t e;
    txn_t t;
    if (c_q.size() > 0) begin
      e = c_q.pop_front();
      if (a_q.size() > 0 && a_q[0].cyc == cyc - 1) begin
        t = a_q.pop_front();
        chk("a_valid", {31'b0, a_valid}, 1);
        chk("a_err", {31'b0, a_err}, {31'b0, t.err});
        chk("a_dout", a_dout, t.dout);
        $display("A txn cyc=%0d dout=%h err=%b", t.cyc, a_dout, a_err);
      end else begin
        chk("a_valid_idle", {31'b0, a_valid}, 0);
        chk("a_err_idle", {31'b0, a_err}, 0);
      end
      chk("a_dout_hold", a_dout, e.a_hold);
      if (b_q.size() > 0 && b_q[0].cyc == cyc - 1) begin
        t = b_q.pop_front();
        chk("b_valid", {31'b0, b_valid}, 1);
        chk("b_err", {31'b0, b_err}, {31'b0, t.err});
        chk("b_dout", b_dout, t.dout);
        $display("B txn cyc=%0d dout=%h err=%b", t.cyc, b_dout, b_err);
      end else begin
        chk("b_valid_idle", {31'b0, b_valid}, 0);
        chk("b_err_idle", {31'b0, b_err}, 0);
      end
      chk("b_dout_hold", b_dout, e.b_hold);
      chk("err_sticky", {31'b0, err_sticky}, {31'b0, e.sticky});
    end
  end

  initial begin
    logic [AW-1:0] ra, rb;
    rst = 1'b1; a_rd_en = 0; a_addr = 0; b_rd_en = 0; b_wr_en = 0;
    b_be = 0; b_addr = 0; b_din = 0; err_clr = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Fill every word so the model and the array agree everywhere
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), $urandom, 4'hF);

    // Write then read on both ports
    wr(5, 32'hDEADBEEF, 4'hF);
    step(0, 1, 5, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 5, 0, 0);

    // Byte enables
    wr(7, 32'h11223344, 4'hF);
    wr(7, 32'hAABBCCDD, 4'b0101);
    step(0, 0, 0, 1, 0, 0, 7, 0, 0);

    // Same-cycle read+write on port B
    wr(9, 32'h0, 4'hF);
    step(0, 0, 0, 1, 1, 4'h3, 9, 32'h0000FFFF, 0);
    idle();

    // Cross-port collision
    wr(3, 32'h1, 4'hF);
    step(0, 1, 3, 0, 1, 4'hF, 3, 32'h2, 0);
    step(0, 1, 3, 0, 0, 0, 0, 0, 0);

    // Out-of-range, sticky error and clear
    step(0, 0, 0, 0, 1, 4'hF, 16'd512, 32'hCAFEF00D, 0);
    step(0, 1, 16'hFFFF, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    // Clear coinciding with a new error: the error wins
    step(0, 1, 16'd600, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Reset mid-operation
    wr(4, 32'h12345678, 4'hF);
    step(1, 1, 4, 0, 1, 4'hF, 4, 32'h55, 0);
    idle();
    step(0, 1, 4, 1, 0, 0, 4, 0, 0);

    // Random traffic with occasional resets, clears and collisions
    for (int n = 0; n < 1500; n++) begin
      ra = ($urandom_range(0, 19) == 0) ? AW'(DEPTH + $urandom_range(0, 7))
                                        : AW'($urandom_range(0, DEPTH - 1));
      rb = ($urandom_range(0, 3) == 0) ? ra
         : ($urandom_range(0, 24) == 0) ? 16'hFFFF
         : AW'($urandom_range(0, DEPTH - 1));
      step(($urandom_range(0, 99) == 0), 1'($urandom), ra, 1'($urandom),
           1'($urandom), 4'($urandom), rb, $urandom,
           ($urandom_range(0, 9) == 0));
    end

    idle();
    idle();
    chk("a_q_drained", 32'(a_q.size()), 0);
    chk("b_q_drained", 32'(b_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
